ml_sched_ctrl: RTL and testbench

Controller and scheduler that wraps the ML demodulation datapath.
- Queues incoming (y_hat, r) vectors on i_trig.
- Issues one start per vector to the datapath and waits for its done.
- Buffers each 8-bit hard-decision/LLR result.
- Serializes results bit-by-bit on the o_rd_vld/i_rd_rdy handshake, so bursty downstream readiness never loses data.

---
 rtl/ml_pkg.sv | 23 ++
 rtl/ml_sched_fifo.sv | 72 +++++++
 rtl/ml_sched_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ml_sched_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ml_pkg.sv
// Shared state encoding, datapath widths and result-entry layout for the ML
// demodulation scheduler.
package ml_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_WRITE = 2'd3
    } sched_state_t;

    localparam int Y_HAT_W       = 160;
    localparam int R_W           = 320;
    localparam int NUM_BITS      = 8;
    localparam int LLR_W_DEFAULT = 8;
    localparam int IN_ENTRY_W    = Y_HAT_W + R_W;

    // Result entry is {hb[NUM_BITS-1:0], llr[NUM_BITS*llr_w-1:0]}, hard bits on top.
    function automatic int res_entry_w(input int llr_w);
        return NUM_BITS * (llr_w + 1);
    endfunction

endpackage

// File: rtl/ml_sched_fifo.sv
// Circular synchronous FIFO with registered count and registered full/empty.
// A pop in the same cycle never frees room for that cycle's push.
module ml_sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          full_r;
    logic          empty_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify requests against the registered flags and form the next count.
    always_comb begin
        do_push_s   = push && !full_r;
        do_pop_s    = pop && !empty_r;
        count_nxt_s = count_r;
        if (do_push_s && !do_pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (!do_push_s && do_pop_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage, pointers, count and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            empty_r <= (count_nxt_s == {CW{1'b0}});
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/ml_sched_ctrl.sv
// Scheduler around the ML demodulation datapath: queues vectors, sequences the
// datapath, buffers results and streams them bit-serially. ML_SCHED_WDT_EN adds a RUN watchdog.
module ml_sched_ctrl
    import ml_pkg::*;
#(
    parameter int IN_DEPTH   = 2,
    parameter int OUT_DEPTH  = 4,
`ifdef ML_SCHED_WDT_EN
    parameter int WDT_CYCLES = 64,
`endif
    parameter int LLR_W      = LLR_W_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_trig,
    input  logic [Y_HAT_W-1:0]        i_y_hat,
    input  logic [R_W-1:0]            i_r,
    output logic                      o_dp_start,
    output logic [Y_HAT_W-1:0]        o_dp_y_hat,
    output logic [R_W-1:0]            o_dp_r,
    input  logic                      i_dp_done,
    input  logic [NUM_BITS-1:0]       i_dp_hb,
    input  logic [NUM_BITS*LLR_W-1:0] i_dp_llr,
    input  logic                      i_rd_rdy,
    output logic                      o_rd_vld,
    output logic                      o_hard_bit,
    output logic [LLR_W-1:0]          o_llr,
    output logic                      o_overflow,
    output logic                      o_busy
`ifdef ML_SCHED_WDT_EN
    ,
    output logic                      o_wdt_err
`endif
);
    localparam int LLR_VEC_W = NUM_BITS * LLR_W;
    localparam int RES_W     = res_entry_w(LLR_W);

    sched_state_t          state_r;
    logic                  dp_start_r;
    logic                  busy_r;
    logic                  overflow_r;
    logic [NUM_BITS-1:0]   hb_r;
    logic [LLR_VEC_W-1:0]  llr_r;
    logic [2:0]            cnt_r;
    logic [IN_ENTRY_W-1:0] in_head_s;
    logic [RES_W-1:0]      res_head_s;
    logic                  in_full_s;
    logic                  in_empty_s;
    logic                  res_full_s;
    logic                  res_empty_s;
    logic                  in_pop_s;
    logic                  res_push_s;
    logic                  res_pop_s;
    logic                  xfer_s;
`ifdef ML_SCHED_WDT_EN
    localparam int WDT_CW = $clog2(WDT_CYCLES + 1);
    logic [WDT_CW-1:0]     wdt_cnt_r;
    logic                  wdt_err_r;
`endif

    ml_sched_fifo #(.W(IN_ENTRY_W), .DEPTH(IN_DEPTH)) u_in_q (
        .clk(i_clk), .rst_n(i_reset), .push(i_trig), .pop(in_pop_s),
        .din({i_y_hat, i_r}), .dout(in_head_s), .full(in_full_s), .empty(in_empty_s)
    );

    ml_sched_fifo #(.W(RES_W), .DEPTH(OUT_DEPTH)) u_res_q (
        .clk(i_clk), .rst_n(i_reset), .push(res_push_s), .pop(res_pop_s),
        .din({hb_r, llr_r}), .dout(res_head_s), .full(res_full_s), .empty(res_empty_s)
    );

    // WRITE retires the head vector; the 8th transfer retires the head result.
    always_comb begin
        in_pop_s   = (state_r == ST_WRITE);
        res_push_s = (state_r == ST_WRITE);
        xfer_s     = !res_empty_s && i_rd_rdy;
        res_pop_s  = xfer_s && (cnt_r == 3'd7);
    end

    // Scheduler FSM with registered start/busy and captured datapath result.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r    <= ST_IDLE;
            dp_start_r <= 1'b0;
            busy_r     <= 1'b0;
            hb_r       <= {NUM_BITS{1'b0}};
            llr_r      <= {LLR_VEC_W{1'b0}};
`ifdef ML_SCHED_WDT_EN
            wdt_cnt_r  <= {WDT_CW{1'b0}};
            wdt_err_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!in_empty_s && !res_full_s) begin
                        state_r    <= ST_START;
                        dp_start_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        dp_start_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_START: begin
                    state_r    <= ST_RUN;
                    dp_start_r <= 1'b0;
`ifdef ML_SCHED_WDT_EN
                    wdt_cnt_r  <= {WDT_CW{1'b0}};
`endif
                end
                ST_RUN: begin
                    if (i_dp_done) begin
                        hb_r    <= i_dp_hb;
                        llr_r   <= i_dp_llr;
                        state_r <= ST_WRITE;
                    end
`ifdef ML_SCHED_WDT_EN
                    // A zero result keeps one entry per vector in the output stream.
                    else if (wdt_cnt_r >= WDT_CW'(WDT_CYCLES - 1)) begin
                        hb_r      <= {NUM_BITS{1'b0}};
                        llr_r     <= {LLR_VEC_W{1'b0}};
                        wdt_err_r <= 1'b1;
                        state_r   <= ST_WRITE;
                    end else begin
                        wdt_cnt_r <= wdt_cnt_r + WDT_CW'(1);
                    end
`else
                    else begin
                        state_r <= ST_RUN;
                    end
`endif
                end
                ST_WRITE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    dp_start_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Bit pointer into the head result; wraps to 0 as the entry is popped.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_r <= 3'd0;
        end else if (xfer_s) begin
            cnt_r <= cnt_r + 3'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sticky flag for a trigger dropped against a full input queue.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            overflow_r <= 1'b0;
        end else if (i_trig && in_full_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign o_dp_start = dp_start_r;
    assign o_busy     = busy_r;
    assign o_overflow = overflow_r;
    assign o_dp_y_hat = in_head_s[IN_ENTRY_W-1 -: Y_HAT_W];
    assign o_dp_r     = in_head_s[R_W-1:0];
    assign o_rd_vld   = !res_empty_s;
    assign o_hard_bit = res_head_s[LLR_VEC_W + int'(cnt_r)];
    assign o_llr      = res_head_s[int'(cnt_r)*LLR_W +: LLR_W];
`ifdef ML_SCHED_WDT_EN
    assign o_wdt_err  = wdt_err_r;
`endif

endmodule

// File: tb/tb_ml_sched_ctrl.sv
// Directed bench for ml_sched_ctrl: a latency-programmable datapath model and a
// read-side monitor feed per-scenario tasks that compare against hand-derived values.
module tb_ml_sched_ctrl;
    import ml_pkg::*;

    localparam int LLR_W = 8;

    logic                 i_clk;
    logic                 i_reset;
    logic                 i_trig;
    logic [Y_HAT_W-1:0]   i_y_hat;
    logic [R_W-1:0]       i_r;
    logic                 o_dp_start;
    logic [Y_HAT_W-1:0]   o_dp_y_hat;
    logic [R_W-1:0]       o_dp_r;
    logic                 i_dp_done;
    logic [7:0]           i_dp_hb;
    logic [8*LLR_W-1:0]   i_dp_llr;
    logic                 i_rd_rdy;
    logic                 o_rd_vld;
    logic                 o_hard_bit;
    logic [LLR_W-1:0]     o_llr;
    logic                 o_overflow;
    logic                 o_busy;
`ifdef ML_SCHED_WDT_EN
    logic                 o_wdt_err;
`endif

    int errors = 0;
    int checks = 0;
    int dp_lat = 20;
    bit dp_en = 1'b1;
    int dp_wait = 0;
    int dp_idx = 0;
    int start_cnt = 0;
    bit         rx_hb[$];
    logic [7:0] rx_llr[$];

    ml_sched_ctrl #(.IN_DEPTH(2), .OUT_DEPTH(4), .LLR_W(LLR_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_trig(i_trig), .i_y_hat(i_y_hat), .i_r(i_r),
        .o_dp_start(o_dp_start), .o_dp_y_hat(o_dp_y_hat), .o_dp_r(o_dp_r),
        .i_dp_done(i_dp_done), .i_dp_hb(i_dp_hb), .i_dp_llr(i_dp_llr),
        .i_rd_rdy(i_rd_rdy), .o_rd_vld(o_rd_vld), .o_hard_bit(o_hard_bit), .o_llr(o_llr),
        .o_overflow(o_overflow), .o_busy(o_busy)
`ifdef ML_SCHED_WDT_EN
        , .o_wdt_err(o_wdt_err)
`endif
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Datapath reference results, indexed by completion order.
    function automatic logic [7:0] exp_hb(input int i);
        logic [7:0] v;
        v = i[7:0];
        return 8'hA5 + v * 8'd37;
    endfunction

    function automatic logic [7:0] exp_llr(input int i, input int k);
        logic [7:0] a;
        logic [7:0] b;
        a = i[7:0];
        b = k[7:0];
        return (a * 8'd16) ^ (b * 8'd3) ^ 8'h11;
    endfunction

    // Datapath model: done dp_lat cycles after each observed start.
    initial begin : dp_model
        i_dp_done = 1'b0;
        i_dp_hb   = 8'h00;
        i_dp_llr  = '0;
        forever begin
            @(posedge i_clk); #1;
            i_dp_done = 1'b0;
            if (dp_wait > 0) begin
                dp_wait = dp_wait - 1;
                if (dp_wait == 0) begin
                    i_dp_hb = exp_hb(dp_idx);
                    for (int k = 0; k < 8; k++) i_dp_llr[k*LLR_W +: LLR_W] = exp_llr(dp_idx, k);
                    i_dp_done = 1'b1;
                    dp_idx++;
                end
            end else if (o_dp_start) begin
                start_cnt++;
                if (dp_en) dp_wait = dp_lat;
            end
        end
    end

    // Read-side monitor: records every bit that transfers at the next edge.
    initial begin : rd_monitor
        forever begin
            @(negedge i_clk);
            if (i_reset && o_rd_vld && i_rd_rdy) begin
                rx_hb.push_back(o_hard_bit);
                rx_llr.push_back(o_llr);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic send_vec(input logic [31:0] tag);
        i_y_hat = {5{tag}};
        i_r     = {10{~tag}};
        i_trig  = 1'b1;
        tick(1);
        i_trig  = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int c = 0; c < budget && rx_hb.size() < n; c++) tick(1);
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_trig = 1'b0; i_rd_rdy = 1'b0; i_y_hat = '0; i_r = '0;
        tick(3);
        @(negedge i_clk);
        checks++;
        if ({o_dp_start, o_rd_vld, o_hard_bit, o_overflow, o_busy} !== 5'b00000)
            begin errors++; $display("FAIL reset_ctl: got %b expected 00000", {o_dp_start, o_rd_vld, o_hard_bit, o_overflow, o_busy}); end
        checks++;
        if (o_llr !== 8'h00) begin errors++; $display("FAIL reset_llr: got %h expected 00", o_llr); end
        checks++;
        if (o_dp_y_hat !== '0 || o_dp_r !== '0) begin errors++; $display("FAIL reset_head: got nonzero expected 0"); end
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        tick(2);
        checks++;
        if (o_busy !== 1'b0 || o_rd_vld !== 1'b0) begin errors++; $display("FAIL reset_release: busy=%b vld=%b expected 0 0", o_busy, o_rd_vld); end
    endtask

    task automatic test_single();
        logic [7:0] want;
        logic [7:0] obs;
        want = 8'hA5;
        rx_hb.delete(); rx_llr.delete();
        dp_lat = 20; i_rd_rdy = 1'b1;
        send_vec(32'hC0DE0001);
        @(negedge i_clk);
        checks++;
        if (o_dp_start !== 1'b0) begin errors++; $display("FAIL single_start_t1: got %b expected 0", o_dp_start); end
        @(posedge i_clk); #1;
        @(negedge i_clk);
        checks++;
        if (o_dp_start !== 1'b1) begin errors++; $display("FAIL single_start_t2: got %b expected 1", o_dp_start); end
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", o_busy); end
        @(posedge i_clk); #1;
        @(negedge i_clk);
        checks++;
        if (o_dp_start !== 1'b0) begin errors++; $display("FAIL single_start_t3: got %b expected 0", o_dp_start); end
        checks++;
        if (o_dp_y_hat !== {5{32'hC0DE0001}} || o_dp_r !== {10{~32'hC0DE0001}})
            begin errors++; $display("FAIL single_head: got %h expected %h", o_dp_y_hat[31:0], 32'hC0DE0001); end
        @(posedge i_clk); #1;
        wait_rx(8, 100);
        obs = 8'h00;
        for (int j = 0; j < 8 && j < rx_hb.size(); j++) obs[j] = rx_hb[j];
        checks++;
        if (rx_hb.size() != 8 || obs !== want) begin errors++; $display("FAIL single_bits: got %h (%0d bits) expected %h", obs, rx_hb.size(), want); end
        for (int j = 0; j < 8 && j < rx_llr.size(); j++) begin
            checks++;
            if (rx_llr[j] !== exp_llr(0, j)) begin errors++; $display("FAIL single_llr%0d: got %h expected %h", j, rx_llr[j], exp_llr(0, j)); end
        end
        @(negedge i_clk);
        checks++;
        if (o_rd_vld !== 1'b0) begin errors++; $display("FAIL single_vld_fall: got %b expected 0", o_rd_vld); end
        @(posedge i_clk); #1;
    endtask

    task automatic test_stream(input int nvec);
        int base;
        logic [7:0] h;
        logic [7:0] obs;
        int bad;
        rx_hb.delete(); rx_llr.delete();
        base = dp_idx; dp_lat = 20;
        for (int c = 0; c < nvec * 64; c++) begin
            i_rd_rdy = ((c / 128) % 2 == 0);
            i_trig   = (c % 64 == 0);
            i_y_hat  = {5{c}};
            i_r      = {10{c}};
            tick(1);
        end
        i_trig = 1'b0; i_rd_rdy = 1'b1;
        wait_rx(nvec * 8, 2000);
        checks++;
        if (rx_hb.size() != nvec * 8) begin errors++; $display("FAIL stream_count: got %0d expected %0d", rx_hb.size(), nvec * 8); end
        for (int v = 0; v < nvec && (v * 8 + 7) < rx_hb.size(); v++) begin
            h = exp_hb(base + v);
            obs = 8'h00; bad = 0;
            for (int k = 0; k < 8; k++) begin
                obs[k] = rx_hb[v*8 + k];
                if (rx_llr[v*8 + k] !== exp_llr(base + v, k)) bad++;
            end
            checks++;
            if (obs !== h || bad != 0) begin errors++; $display("FAIL stream_vec%0d: got hb %h (%0d llr errs) expected hb %h", v, obs, bad, h); end
        end
        checks++;
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL stream_overflow: got %b expected 0", o_overflow); end
    endtask

    task automatic test_toggle();
        int base;
        logic [7:0] h;
        logic [7:0] obs;
        int pos;
        rx_hb.delete(); rx_llr.delete();
        base = dp_idx; dp_lat = 5; i_rd_rdy = 1'b0;
        send_vec(32'h0000_7061);
        for (int c = 0; c < 30 && !o_rd_vld; c++) tick(1);
        h = exp_hb(base);
        for (int c = 0; c < 20; c++) begin
            i_rd_rdy = c[0];
            @(negedge i_clk);
            pos = rx_hb.size();
            if (!i_rd_rdy && o_rd_vld && pos < 8) begin
                checks++;
                if (o_hard_bit !== h[pos] || o_llr !== exp_llr(base, pos))
                    begin errors++; $display("FAIL toggle_hold%0d: got %b/%h expected %b/%h", pos, o_hard_bit, o_llr, h[pos], exp_llr(base, pos)); end
            end
            @(posedge i_clk); #1;
        end
        obs = 8'h00;
        for (int j = 0; j < 8 && j < rx_hb.size(); j++) obs[j] = rx_hb[j];
        checks++;
        if (rx_hb.size() != 8 || obs !== h) begin errors++; $display("FAIL toggle_bits: got %h (%0d bits) expected %h", obs, rx_hb.size(), h); end
        checks++;
        if (o_rd_vld !== 1'b0) begin errors++; $display("FAIL toggle_vld: got %b expected 0", o_rd_vld); end
    endtask

    task automatic test_backpressure();
        int base;
        int s0;
        logic [7:0] h;
        logic [7:0] obs;
        rx_hb.delete(); rx_llr.delete();
        base = dp_idx; dp_lat = 5; i_rd_rdy = 1'b0;
        for (int v = 0; v < 4; v++) begin
            send_vec(32'hB0 + v);
            tick(14);
        end
        s0 = start_cnt;
        send_vec(32'hB4);
        tick(20);
        checks++;
        if (start_cnt != s0 || o_busy !== 1'b0) begin errors++; $display("FAIL bp_withheld: starts %0d busy %b expected %0d 0", start_cnt, o_busy, s0); end
        send_vec(32'hB5);
        tick(2);
        checks++;
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL bp_no_ovf: got %b expected 0", o_overflow); end
        send_vec(32'hB6);
        tick(2);
        checks++;
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %b expected 1", o_overflow); end
        i_rd_rdy = 1'b1;
        wait_rx(48, 1000);
        tick(30);
        checks++;
        if (rx_hb.size() != 48) begin errors++; $display("FAIL bp_count: got %0d expected 48", rx_hb.size()); end
        for (int v = 0; v < 6 && (v * 8 + 7) < rx_hb.size(); v++) begin
            h = exp_hb(base + v);
            obs = 8'h00;
            for (int k = 0; k < 8; k++) obs[k] = rx_hb[v*8 + k];
            checks++;
            if (obs !== h || rx_llr[v*8 + 3] !== exp_llr(base + v, 3))
                begin errors++; $display("FAIL bp_vec%0d: got %h expected %h", v, obs, h); end
        end
        checks++;
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky: got %b expected 1", o_overflow); end
    endtask

    task automatic test_reset_mid_run();
        int s0;
        rx_hb.delete(); rx_llr.delete();
        dp_lat = 5; i_rd_rdy = 1'b0;
        send_vec(32'hD0); tick(14);
        send_vec(32'hD1); tick(14);
        dp_lat = 40;
        send_vec(32'hD2); tick(6);
        checks++;
        if (o_busy !== 1'b1 || o_rd_vld !== 1'b1) begin errors++; $display("FAIL rst_pre: busy=%b vld=%b expected 1 1", o_busy, o_rd_vld); end
        #2;
        i_reset = 1'b0;
        #1;
        checks++;
        if (o_rd_vld !== 1'b0 || o_busy !== 1'b0 || o_overflow !== 1'b0)
            begin errors++; $display("FAIL rst_async: vld=%b busy=%b ovf=%b expected 0 0 0", o_rd_vld, o_busy, o_overflow); end
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        s0 = start_cnt;
        i_rd_rdy = 1'b1;
        tick(60);
        checks++;
        if (rx_hb.size() != 0 || o_rd_vld !== 1'b0 || o_busy !== 1'b0 || start_cnt != s0)
            begin errors++; $display("FAIL rst_late_done: bits=%0d vld=%b busy=%b expected 0 0 0", rx_hb.size(), o_rd_vld, o_busy); end
    endtask

`ifdef ML_SCHED_WDT_EN
    task automatic test_wdt();
        int base;
        logic [7:0] obs;
        rx_hb.delete(); rx_llr.delete();
        dp_en = 1'b0; i_rd_rdy = 1'b1;
        send_vec(32'hE0);
        tick(30);
        checks++;
        if (o_wdt_err !== 1'b0) begin errors++; $display("FAIL wdt_early: got %b expected 0", o_wdt_err); end
        tick(60);
        checks++;
        if (o_wdt_err !== 1'b1) begin errors++; $display("FAIL wdt_set: got %b expected 1", o_wdt_err); end
        wait_rx(8, 50);
        obs = 8'hFF;
        for (int j = 0; j < 8 && j < rx_hb.size(); j++) obs[j] = rx_hb[j] | (rx_llr[j] != 8'h00);
        checks++;
        if (rx_hb.size() != 8 || obs !== 8'h00) begin errors++; $display("FAIL wdt_zero: got %h (%0d bits) expected 00", obs, rx_hb.size()); end
        tick(2);
        rx_hb.delete(); rx_llr.delete();
        dp_en = 1'b1; dp_lat = 5; base = dp_idx;
        send_vec(32'hE1);
        wait_rx(8, 60);
        obs = 8'h00;
        for (int j = 0; j < 8 && j < rx_hb.size(); j++) obs[j] = rx_hb[j];
        checks++;
        if (rx_hb.size() != 8 || obs !== exp_hb(base)) begin errors++; $display("FAIL wdt_next: got %h expected %h", obs, exp_hb(base)); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stream(40);
        test_toggle();
        test_backpressure();
        test_reset_mid_run();
`ifdef ML_SCHED_WDT_EN
        test_wdt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
